pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and instruction-fetch stage of the datapath; consumes the next-PC selected by the datapath mux and drives the instruction memory request. Holds the architectural PC, issues one word fetch at a time over a valid/ready request channel, and presents the fetched instruction and its PC to decode through a one-entry output register. Handles redirects (branch/jump) at any time, including dropping a response already in flight.

## Interface
- WIDTH, 32, PC/address and instruction width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- redirect_valid  in  1  load redirect_target as new PC this cycle
- redirect_target  in  WIDTH  next PC from the datapath mux
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  WIDTH  fetch address (current PC)
- imem_resp_valid  in  1  response data valid (one per accepted request)
- imem_resp_data  in  WIDTH  fetched instruction
- if_valid  out  1  output register holds an instruction
- if_ready  in  1  decode consumes output this cycle
- if_pc  out  WIDTH  PC of instruction in output register
- if_instr  out  WIDTH  instruction in output register
- misalign  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN. Reset state IDLE.
- IDLE -> REQ unconditionally next cycle.
- REQ: imem_req_valid=1, imem_addr=pc. Handshake (valid&&ready) -> WAIT.
- WAIT: on imem_resp_valid: load if_pc=pc, if_instr=data, if_valid=1; pc <= pc+4 (mod 2^WIDTH, wraps to 0). Next REQ if output slot is free after this cycle, else HOLD.
- Output slot free = !if_valid || if_ready. Response is accepted only when slot free; otherwise the fetch FSM waits in WAIT (memory keeps resp asserted until this block is in WAIT with free slot — the response is held by memory, this block never drops a non-redirected response).
- HOLD: wait for if_ready, then REQ.
- Redirect (any state except IDLE, highest priority): pc <= redirect_target; if_valid <= 0 (output is squashed). From WAIT with no resp this cycle -> DRAIN; from WAIT with resp this cycle -> response discarded, go REQ; from REQ/HOLD/DRAIN -> REQ (DRAIN keeps drop pending -> stays DRAIN).
- REQ under redirect: if handshake occurs same cycle, request already issued -> DRAIN instead of REQ.
- DRAIN: discard next imem_resp_valid, then REQ.
- At most one outstanding request at any time.

## Timing
- Reset values: pc=RESET_PC, if_valid=0, if_pc=0, if_instr=0, imem_req_valid=0, misalign=0.
- First request: cycle 1 after rst deasserts (IDLE takes one cycle).
- Best case throughput: one instruction per 2 cycles + memory latency (REQ, WAIT).
- Output register updates on the clock edge of the accepted response; if_* registered, no combinational path from imem_resp_* to if_*.
- imem_addr stable while imem_req_valid && !imem_req_ready.
- rst mid-fetch: state forced to IDLE immediately; any response arriving after reset is ignored until a new request is issued.

## Configuration
- PC_FETCH_ALIGN_CHECK_EN defined: redirect_target with bits[1:0]!=0 sets misalign (sticky until rst), and the loaded PC has bits[1:0] forced to 0.
- Undefined: redirect_target loaded unmodified; misalign tied to 0.

## Structure
- Shared package pc_fetch_pkg: state enum (IDLE, REQ, WAIT, HOLD, DRAIN), PC_INC=4 constant.
- Sub-module pc_incr: WIDTH-bit +PC_INC adder, purely combinational.

## Test plan
- Reset release, memory always ready, 1-cycle response with data 32'hAAAA0000+addr -> if_pc 0,4,8 with matching if_instr, first if_valid on cycle 3.
- if_ready held 0 for 5 cycles after first instruction -> if_pc stays 0, no new imem request until if_ready, then fetch at 4.
- Redirect to 32'h0000_0100 while in WAIT, response arrives 2 cycles later -> response discarded, next imem_addr 32'h100, if_pc 32'h100.
- Redirect same cycle as imem_resp_valid -> instruction not presented, if_valid 0, next request at target.
- PC=32'hFFFF_FFFC fetch completes -> next imem_addr 32'h0 (wrap).
- With PC_FETCH_ALIGN_CHECK_EN, redirect to 32'h0000_0106 -> imem_addr 32'h104, misalign=1 and remains 1 until rst.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch stage.
package pc_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam int PC_INC = 4;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response channel; master = fetch stage, slave = memory.
interface pc_fetch_if #(
    parameter int WIDTH = 32
);
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_resp_valid;
    logic [WIDTH-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/pc_fetch_incr.sv
// Combinational next-sequential-PC adder (wraps modulo 2^WIDTH).
module pc_incr
    import pc_fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus
);
    assign pc_plus = pc + WIDTH'(PC_INC);
endmodule

// File: rtl/pc_fetch.sv
// PC register, single-outstanding instruction fetch and one-entry decode output register.
// Optional build macro PC_FETCH_ALIGN_CHECK_EN: word-align redirect targets and flag misalignment.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int             WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    pc_fetch_if.master       imem,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_instr,
    output logic             misalign
);

    state_t           state_reg;
    logic             req_valid_reg;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] pc_plus;
    logic             if_valid_reg;
    logic [WIDTH-1:0] if_pc_reg;
    logic [WIDTH-1:0] if_instr_reg;

    logic             hs;
    logic             slot_free;
    logic             redirect_take;
    logic             accept;
    logic             drop_pending;
    logic [WIDTH-1:0] target_pc;

    pc_incr #(.WIDTH(WIDTH)) u_incr (
        .pc      (pc_reg),
        .pc_plus (pc_plus)
    );

    assign hs            = req_valid_reg && imem.imem_req_ready;
    assign slot_free     = !if_valid_reg || if_ready;
    assign redirect_take = redirect_valid && (state_reg != IDLE);
    assign accept        = (state_reg == WAIT) && imem.imem_resp_valid && slot_free && !redirect_take;

    // A redirect leaves a response owed by memory when a request is in flight
    // and its data has not shown up in this same cycle.
    always_comb begin
        drop_pending = 1'b0;
        case (state_reg)
            WAIT, DRAIN: drop_pending = !imem.imem_resp_valid;
            REQ:         drop_pending = hs;
            default:     drop_pending = 1'b0;
        endcase
    end

`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic misalign_reg;

    assign target_pc = {redirect_target[WIDTH-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_reg <= 1'b0;
        end else if (redirect_take && (redirect_target[1:0] != 2'b00)) begin
            misalign_reg <= 1'b1;
        end
    end

    assign misalign = misalign_reg;
`else
    assign target_pc = redirect_target;
    assign misalign  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            req_valid_reg <= 1'b0;
        end else if (redirect_take) begin
            if (drop_pending) begin
                state_reg     <= DRAIN;
                req_valid_reg <= 1'b0;
            end else begin
                state_reg     <= REQ;
                req_valid_reg <= 1'b1;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg     <= REQ;
                    req_valid_reg <= 1'b1;
                end
                REQ: begin
                    if (hs) begin
                        state_reg     <= WAIT;
                        req_valid_reg <= 1'b0;
                    end
                end
                WAIT: begin
                    // Only fetch ahead when decode is draining; otherwise park in HOLD.
                    if (accept) begin
                        if (if_ready) begin
                            state_reg     <= REQ;
                            req_valid_reg <= 1'b1;
                        end else begin
                            state_reg     <= HOLD;
                            req_valid_reg <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (if_ready) begin
                        state_reg     <= REQ;
                        req_valid_reg <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (imem.imem_resp_valid) begin
                        state_reg     <= REQ;
                        req_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    req_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            if_valid_reg <= 1'b0;
            if_pc_reg    <= '0;
            if_instr_reg <= '0;
        end else if (redirect_take) begin
            pc_reg       <= target_pc;
            if_valid_reg <= 1'b0;
        end else if (accept) begin
            pc_reg       <= pc_plus;
            if_valid_reg <= 1'b1;
            if_pc_reg    <= pc_reg;
            if_instr_reg <= imem.imem_resp_data;
        end else if (if_ready) begin
            if_valid_reg <= 1'b0;
        end
    end

    assign imem.imem_req_valid = req_valid_reg;
    assign imem.imem_addr      = pc_reg;
    assign if_valid            = if_valid_reg;
    assign if_pc               = if_pc_reg;
    assign if_instr            = if_instr_reg;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed vector table and corner sequences, then random traffic
// against a memory responder and a decode-stream reference model.
module tb_pc_fetch;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             redirect_valid = 1'b0;
    logic [WIDTH-1:0] redirect_target = '0;
    logic             if_ready = 1'b1;
    logic             if_valid;
    logic [WIDTH-1:0] if_pc;
    logic [WIDTH-1:0] if_instr;
    logic             misalign;

    always #5 clk = ~clk;

    pc_fetch_if #(.WIDTH(WIDTH)) imem ();

    pc_fetch #(.WIDTH(WIDTH), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem            (imem),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .misalign        (misalign)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hAAAA_0000 + a;
    endfunction

    function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef PC_FETCH_ALIGN_CHECK_EN
        return t & 32'hFFFF_FFFC;
`else
        return t;
`endif
    endfunction

    // ---------------- posedge snapshot of everything the edge saw ----------------
    logic        s_rst = 1'b1, s_req = 1'b0, s_rdy = 1'b0, s_resp = 1'b0;
    logic        s_ifv = 1'b0, s_ifr = 1'b0, s_redir = 1'b0;
    logic [31:0] s_addr = '0, s_pc = '0, s_instr = '0, s_tgt = '0;

    always @(posedge clk) begin
        s_rst   = rst;
        s_req   = imem.imem_req_valid;
        s_rdy   = imem.imem_req_ready;
        s_addr  = imem.imem_addr;
        s_resp  = imem.imem_resp_valid;
        s_ifv   = if_valid;
        s_ifr   = if_ready;
        s_pc    = if_pc;
        s_instr = if_instr;
        s_redir = redirect_valid;
        s_tgt   = redirect_target;
    end

    // ---------------- memory responder + decode-stream model ----------------
    logic        mem_rand = 1'b0;
    int          mem_lat = 1;
    int          countdown = 0;
    int          outstanding = 0;
    logic [31:0] pend_addr = '0;
    logic        sb_en = 1'b0;
    logic        exp_known = 1'b0;
    logic [31:0] exp_pc = '0;
    int          n_consumed = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        if (rst) begin
            imem.imem_req_ready  = 1'b1;
            imem.imem_resp_valid = 1'b0;
            imem.imem_resp_data  = '0;
            countdown   = 0;
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (!s_rst) begin
                if (prev_stall && s_req) check("addr_stable", s_addr, prev_addr);
                prev_stall = s_req && !s_rdy && !s_redir;
                prev_addr  = s_addr;

                if (s_redir) begin
                    if (sb_en) begin
                        exp_pc    = eff_target(s_tgt);
                        exp_known = 1'b1;
                    end
                end else if (s_ifv && s_ifr) begin
                    $display("txn pc=%h instr=%h", s_pc, s_instr);
                    if (sb_en) begin
                        if (exp_known) check("stream_pc", s_pc, exp_pc);
                        check("stream_instr", s_instr, instr_of(s_pc));
                        exp_pc    = s_pc + 32'd4;
                        exp_known = 1'b1;
                        n_consumed++;
                    end
                end

                // Block either took or discarded the data at that edge.
                if (s_resp && (!s_ifv || s_ifr || s_redir)) begin
                    imem.imem_resp_valid = 1'b0;
                    outstanding--;
                end
                if (s_req && s_rdy) begin
                    check("one_outstanding", 32'(outstanding), 32'd0);
                    pend_addr = s_addr;
                    countdown = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
                    outstanding++;
                end
                if (countdown > 0) begin
                    countdown--;
                    if (countdown == 0) begin
                        imem.imem_resp_valid = 1'b1;
                        imem.imem_resp_data  = instr_of(pend_addr);
                    end
                end
            end
            imem.imem_req_ready = mem_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[12];

    task automatic wait_req();
        int n = 0;
        while (!imem.imem_req_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("wait_req", {31'd0, imem.imem_req_valid}, 32'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!if_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", {31'd0, if_valid}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 32'h4, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
        vecs[10] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 32'hC, 1'b1, 32'h8};

        repeat (3) @(negedge clk);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_req_valid", {31'd0, imem.imem_req_valid}, 32'd0);
        check("rst_addr", imem.imem_addr, 32'h0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if_ready = vecs[i].rdy;
            @(negedge clk);
            $display("vec %0d req=%0b addr=%h vld=%0b pc=%h", i + 1,
                     imem.imem_req_valid, imem.imem_addr, if_valid, if_pc);
            check($sformatf("vec%0d_req", i + 1), {31'd0, imem.imem_req_valid}, {31'd0, vecs[i].req});
            if (vecs[i].req) check($sformatf("vec%0d_addr", i + 1), imem.imem_addr, vecs[i].addr);
            check($sformatf("vec%0d_vld", i + 1), {31'd0, if_valid}, {31'd0, vecs[i].vld});
            if (vecs[i].vld) begin
                check($sformatf("vec%0d_pc", i + 1), if_pc, vecs[i].pc);
                check($sformatf("vec%0d_instr", i + 1), if_instr, instr_of(vecs[i].pc));
            end
        end
        if_ready = 1'b1;

        // Redirect while waiting; stale response arrives two cycles later.
        wait_req();
        mem_lat = 3;
        @(negedge clk);
        check("wait_no_req", {31'd0, imem.imem_req_valid}, 32'd0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        @(negedge clk);
        redirect_valid = 1'b0;
        mem_lat = 1;
        check("wait_redir_squash", {31'd0, if_valid}, 32'd0);
        wait_req();
        check("wait_redir_addr", imem.imem_addr, 32'h100);
        wait_valid();
        check("wait_redir_pc", if_pc, 32'h100);
        check("wait_redir_instr", if_instr, instr_of(32'h100));

        // Redirect in the same cycle the response shows up.
        wait_req();
        @(negedge clk);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("same_cycle_vld", {31'd0, if_valid}, 32'd0);
        check("same_cycle_req", {31'd0, imem.imem_req_valid}, 32'd1);
        check("same_cycle_addr", imem.imem_addr, 32'h200);
        wait_valid();
        check("same_cycle_pc", if_pc, 32'h200);

        // Redirect on a handshaking REQ, then PC wrap past the top of memory.
        wait_req();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_valid();
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_instr", if_instr, instr_of(32'hFFFF_FFFC));
        check("wrap_addr", imem.imem_addr, 32'h0);
        @(negedge clk);
        wait_valid();
        check("wrap_next_pc", if_pc, 32'h0);

        // Unaligned redirect target.
        wait_req();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0106;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_req();
`ifdef PC_FETCH_ALIGN_CHECK_EN
        check("align_addr", imem.imem_addr, 32'h104);
        check("align_misalign", {31'd0, misalign}, 32'd1);
        wait_valid();
        check("align_pc", if_pc, 32'h104);
`else
        check("noalign_addr", imem.imem_addr, 32'h106);
        check("noalign_misalign", {31'd0, misalign}, 32'd0);
        wait_valid();
        check("noalign_pc", if_pc, 32'h106);
`endif

        // Random traffic against the reference model.
        mem_rand = 1'b1;
        sb_en    = 1'b1;
        @(negedge clk);
        redirect_valid  = 1'b1;
        redirect_target = $urandom() & 32'hFFFF_FFFC;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if_ready        = ($urandom_range(0, 3) != 0);
            redirect_valid  = ($urandom_range(0, 24) == 0);
            redirect_target = $urandom();
`ifndef PC_FETCH_ALIGN_CHECK_EN
            redirect_target = redirect_target & 32'hFFFF_FFFC;
`endif
        end
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        mem_rand       = 1'b0;
        repeat (20) @(negedge clk);
        sb_en = 1'b0;
        check("random_progress", {31'd0, (n_consumed > 100)}, 32'd1);
`ifdef PC_FETCH_ALIGN_CHECK_EN
        check("misalign_sticky", {31'd0, misalign}, 32'd1);
`endif

        // Asynchronous reset in mid-fetch, then restart from RESET_PC.
        wait_valid();
        #2 rst = 1'b1;
        #1;
        check("async_rst_vld", {31'd0, if_valid}, 32'd0);
        check("async_rst_req", {31'd0, imem.imem_req_valid}, 32'd0);
        check("async_rst_misalign", {31'd0, misalign}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_valid();
        check("restart_pc", if_pc, 32'h0);
        check("restart_instr", if_instr, instr_of(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
